// File: rtl/button_debouncer_if.sv
// Board-button side of the debouncer: raw pins in, clean levels and strobes out.
// The master drives the raw pins; the debouncer is the slave.
interface button_debouncer_if;
  logic btn_sum_raw;
  logic btn_res_raw;
  logic sum;
  logic res;
  logic sum_press;
  logic sum_release;
  logic res_press;
  logic res_release;

  modport master (
    output btn_sum_raw, btn_res_raw,
    input  sum, res, sum_press, sum_release, res_press, res_release
  );

  modport slave (
    input  btn_sum_raw, btn_res_raw,
    output sum, res, sum_press, sum_release, res_press, res_release
  );
endinterface

// File: rtl/button_debouncer.sv
// Two independent push-button channels: polarity normalize, 2-flop synchronize,
// then a stability-count filter producing a clean level plus press/release strobes.
module button_debouncer #(
  parameter int STABLE_CYCLES = 240000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input logic               clk,
  input logic               reset,
  button_debouncer_if.slave bus
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [1:0] raw;
  assign raw = {bus.btn_res_raw, bus.btn_sum_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic          n;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          out_q,   out_d;
    logic          press_q, press_d;
    logic          rel_q,   rel_d;

    assign n = ACTIVE_LOW ? ~raw[ch] : raw[ch];

    always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sync1_d = n;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      press_d = 1'b0;
      rel_d   = 1'b0;

      if (sync2_q == out_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        out_d   = sync2_q;
        cnt_d   = '0;
        press_d = sync2_q;
        rel_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // NOTE: reset is synchronous here (no reset in the sensitivity list); flops use <= only.
    always_ff @(posedge clk) begin
      if (!reset) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        out_q   <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        cnt_q   <= cnt_d;
        out_q   <= out_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end
  end

  assign bus.sum         = g_ch[0].out_q;
  assign bus.sum_press   = g_ch[0].press_q;
  assign bus.sum_release = g_ch[0].rel_q;
  assign bus.res         = g_ch[1].out_q;
  assign bus.res_press   = g_ch[1].press_q;
  assign bus.res_release = g_ch[1].rel_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer against a window-based
// reference: an output flips once its last STABLE_CYCLES synchronized samples all disagree with it.
module tb_button_debouncer;
  localparam int S  = 4;
  localparam bit AL = 1'b1;
  localparam bit PRESSED  = AL ? 1'b0 : 1'b1;
  localparam bit RELEASED = ~PRESSED;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  button_debouncer_if bus ();

  button_debouncer #(.STABLE_CYCLES(S), .ACTIVE_LOW(AL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state per channel (0 = sum, 1 = res).
  bit m_sync0 [2];
  bit m_sync1 [2];
  bit m_out   [2];
  bit m_press [2];
  bit m_rel   [2];
  bit hist0 [$];
  bit hist1 [$];

  function automatic logic [5:0] dut_vec();
    return {bus.sum, bus.res, bus.sum_press, bus.sum_release, bus.res_press, bus.res_release};
  endfunction

  function automatic logic [5:0] mdl_vec();
    return {m_out[0], m_out[1], m_press[0], m_rel[0], m_press[1], m_rel[1]};
  endfunction

  function automatic bit window_flips(input bit h [$], input bit cur);
    if (h.size() != S) return 1'b0;
    foreach (h[i]) if (h[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  // Advance one clock edge and update the reference with the pre-edge inputs.
  task automatic tick();
    bit rst_v;
    bit n [2];
    bit s2;
    rst_v = reset;
    n[0] = AL ? ~bus.btn_sum_raw : bus.btn_sum_raw;
    n[1] = AL ? ~bus.btn_res_raw : bus.btn_res_raw;
    @(posedge clk);
    if (!rst_v) begin
      for (int c = 0; c < 2; c++) begin
        m_sync0[c] = 0; m_sync1[c] = 0; m_out[c] = 0; m_press[c] = 0; m_rel[c] = 0;
      end
      hist0.delete();
      hist1.delete();
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit flip;
        s2 = m_sync1[c];
        if (c == 0) begin
          hist0.push_back(s2);
          if (hist0.size() > S) void'(hist0.pop_front());
          flip = window_flips(hist0, m_out[c]);
        end else begin
          hist1.push_back(s2);
          if (hist1.size() > S) void'(hist1.pop_front());
          flip = window_flips(hist1, m_out[c]);
        end
        m_press[c] = 0;
        m_rel[c]   = 0;
        if (flip) begin
          m_out[c]   = ~m_out[c];
          m_press[c] = m_out[c];
          m_rel[c]   = ~m_out[c];
        end
        m_sync1[c] = m_sync0[c];
        m_sync0[c] = n[c];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.btn_sum_raw = RELEASED;
    bus.btn_res_raw = RELEASED;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dut_vec() !== 6'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, dut_vec(), 6'b0);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (dut_vec() !== 6'b0 || dut_vec() !== mdl_vec()) begin
      failures++;
      $display("FAIL reset_idle: got %b want %b", dut_vec(), 6'b0);
    end
  endtask

  task automatic test_press();
    int rise_at = -1;
    int press_cnt = 0;
    bus.btn_sum_raw = PRESSED;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.sum === 1'b1 && rise_at < 0) rise_at = i;
      if (bus.sum_press === 1'b1) press_cnt++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL press_cycle[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (rise_at != S + 1) begin
      failures++;
      $display("FAIL press_latency: got edge %0d want %0d", rise_at, S + 1);
    end
    checks++;
    if (press_cnt != 1 || bus.res !== 1'b0) begin
      failures++;
      $display("FAIL press_strobe: got %0d strobes res=%b want 1 strobe res=0", press_cnt, bus.res);
    end
  endtask

  task automatic test_release();
    int fall_at = -1;
    int rel_cnt = 0;
    bus.btn_sum_raw = RELEASED;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.sum === 1'b0 && fall_at < 0) fall_at = i;
      if (bus.sum_release === 1'b1) rel_cnt++;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL release_cycle[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (fall_at != S + 1 || rel_cnt != 1) begin
      failures++;
      $display("FAIL release_latency: got edge %0d strobes %0d want edge %0d strobes 1", fall_at, rel_cnt, S + 1);
    end
  endtask

  task automatic test_bounce();
    int rise_at = -1;
    int strobes = 0;
    for (int r = 0; r < 8; r++) begin
      bus.btn_sum_raw = r[0] ? RELEASED : PRESSED;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (bus.sum_press === 1'b1 || bus.sum_release === 1'b1 || bus.sum === 1'b1) strobes++;
      end
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL bounce_filtered: got %0d active cycles want 0", strobes);
    end
    bus.btn_sum_raw = PRESSED;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.sum === 1'b1 && rise_at < 0) rise_at = i;
    end
    checks++;
    if (rise_at != S + 1) begin
      failures++;
      $display("FAIL bounce_settle: got edge %0d want %0d", rise_at, S + 1);
    end
    bus.btn_sum_raw = RELEASED;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_overlap();
    int sp = 0, rp = 0, sum_rise = -1;
    bus.btn_sum_raw = PRESSED;
    bus.btn_res_raw = PRESSED;
    for (int i = 0; i < 25; i++) begin
      if (i == 2) bus.btn_res_raw = RELEASED;
      if (i == 5) bus.btn_sum_raw = RELEASED;
      tick();
      if (bus.sum_press === 1'b1) sp++;
      if (bus.res_press === 1'b1) rp++;
      if (bus.sum === 1'b1 && sum_rise < 0) sum_rise = i;
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        $display("FAIL overlap_cycle[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    checks++;
    if (sp != 1 || rp != 0 || sum_rise != S + 1) begin
      failures++;
      $display("FAIL overlap_independent: got sp=%0d rp=%0d rise=%0d want sp=1 rp=0 rise=%0d", sp, rp, sum_rise, S + 1);
    end
  endtask

  task automatic test_reset_mid();
    int rise_at = -1;
    int sp = 0;
    bus.btn_sum_raw = PRESSED;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (bus.sum !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_pre: got sum=%b want 1", bus.sum);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_vec() !== 6'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: got %b want %b", dut_vec(), 6'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.sum === 1'b1 && rise_at < 0) rise_at = i;
      if (bus.sum_press === 1'b1) sp++;
    end
    checks++;
    if (rise_at != S + 1 || sp != 1) begin
      failures++;
      $display("FAIL reset_mid_repress: got edge %0d presses %0d want edge %0d presses 1", rise_at, sp, S + 1);
    end
    bus.btn_sum_raw = RELEASED;
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_random();
    int left [2];
    int errs = 0;
    left[0] = 0;
    left[1] = 0;
    for (int i = 0; i < 1500; i++) begin
      if (left[0] == 0) begin
        bus.btn_sum_raw = ~bus.btn_sum_raw;
        left[0] = $urandom_range(1, 2 * S);
      end
      if (left[1] == 0) begin
        bus.btn_res_raw = ~bus.btn_res_raw;
        left[1] = $urandom_range(1, 2 * S);
      end
      left[0]--;
      left[1]--;
      reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (dut_vec() !== mdl_vec()) begin
        failures++;
        errs++;
        if (errs <= 10) $display("FAIL random_cycle[%0d]: got %b want %b", i, dut_vec(), mdl_vec());
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.btn_sum_raw = RELEASED;
    bus.btn_res_raw = RELEASED;
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
Two-channel push-button conditioner placed directly upstream of the 3-bit up/down counter. It takes the raw, asynchronous, bouncing "sum" and "res" board buttons and produces clean, synchronous, glitch-free levels for the counter's sum/res inputs. It also produces single-cycle press/release strobes for other consumers. Each channel has a 2-flop synchronizer followed by a stability-count filter.

Parameters:
STABLE_CYCLES, 240000, consecutive clk cycles a synchronized input must differ from the current output before the output flips (20 ms at 12 MHz); legal range >= 1
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed (input inverted before synchronizer); 0 = raw reads 1 when pressed

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
btn_sum_raw  input  1  raw asynchronous "sum" button pin
btn_res_raw  input  1  raw asynchronous "res" button pin
sum  output  1  debounced level, 1 = pressed; drives counter sum
res  output  1  debounced level, 1 = pressed; drives counter res
sum_press  output  1  one-cycle strobe when sum goes 0->1
sum_release  output  1  one-cycle strobe when sum goes 1->0
res_press  output  1  one-cycle strobe when res goes 0->1
res_release  output  1  one-cycle strobe when res goes 1->0

Behaviour:
- Clock is clk; reset is reset, synchronous, active-low. All state updates occur on the rising edge of clk only.
- Reset (reset==0 at a clk edge):
  - Both synchronizer flops clear to 0 (normalized "released").
  - Filter counters clear to 0.
  - sum, res, and all four strobes clear to 0.
- Normalization: n = ACTIVE_LOW ? ~raw : raw, taken before the synchronizer. Everything downstream uses 1 = pressed.
- Synchronizer: s1 <= n; s2 <= s1. Nothing other than s2 may consume n.
- Counter width: max(1, $clog2(STABLE_CYCLES)) bits.
- Filter, per channel, each edge with reset==1:
  - If s2 == out: cnt <= 0.
  - Else if cnt == STABLE_CYCLES-1: out <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Any single cycle with s2 == out aborts the run; counting restarts from 0 on the next mismatch.
- Latency: let E0 be the first edge that samples a new raw level, held steady thereafter. The output changes on edge E(STABLE_CYCLES+1), i.e. the (STABLE_CYCLES+2)th edge counting E0. The same latency applies to press and release.
- Strobes:
  - Registered and asserted on the same edge that flips the corresponding out; high for exactly one cycle.
  - press when out goes 0->1; release when out goes 1->0.
  - press and release of one channel are never high together.
- The two channels are fully independent: simultaneous presses, overlaps and skew do not interact. No priority or lockout exists here; the counter resolves simultaneous events.
- Reset mid-operation:
  - A partial count is discarded and the outputs go to 0 immediately.
  - If a button is still held when reset deasserts, the full latency from the first post-reset edge applies. The "press" is then re-reported (sum_press fires).
- Bounce shorter than STABLE_CYCLES consecutive cycles at s2 never reaches the outputs.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.

Test Plan:
- STABLE_CYCLES=4, ACTIVE_LOW=1, reset low 3 cycles then high, raw=1 -> sum=res=0, all strobes 0 throughout.
- Pressed raw goes 1->0 at E0 and held 20 cycles -> sum=1 after edge E5, sum_press=1 for exactly that cycle, sum_release=0; res untouched.
- Pressed raw alternates 0/1 for 3 cycles each repeatedly (run length < 4 at s2) -> sum stays 0, no strobes; then held 0 -> sum rises 6 edges after the last transition.
- From sum=1, raw returns to 1 (released) and is held -> sum=0 after 6 edges, sum_release one cycle. A counter instance fed by sum increments by exactly 1 on this falling edge.
- Both raws pressed on the same edge, res released 2 cycles later and sum 5 cycles later -> each output and strobe follows its own channel independently at the required 6-edge latency.
- Button held, sum=1, then reset pulsed low 1 cycle with the button still held -> sum=0 during reset; after reset deasserts, sum returns to 1 on the 6th edge and sum_press fires again.
